// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the shared memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_f;
  logic              stall_m;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one fixed-latency single-port memory
module mem_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state, state_n;
  logic              grant;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              go;
  logic              pick;
  // grant holds the owner of the current/last access (1 = data port), so it doubles as last_grant
  assign go   = bus.i_req | bus.d_req;
  assign pick = (bus.i_req & bus.d_req) ? ~grant : bus.d_req;
  // next-state: IDLE arbitrates, ACCESS counts down the memory latency, RESP pulses ready once
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE   ? (go ? ACCESS : IDLE) :
              state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
  end
  // state, grant, latched request and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && go) begin
        grant   <= pick;
        cnt     <= CW'(LATENCY - 1);
        addr_q  <= pick ? bus.d_addr : bus.i_addr;
        we_q    <= pick & bus.d_we;
        wdata_q <= bus.d_wdata;
      end
      if (state == ACCESS) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0 && !we_q && grant) d_rdata_q <= bus.mem_rdata;
        if (cnt == '0 && !grant) i_rdata_q <= bus.mem_rdata;
      end
    end
  end
  assign bus.mem_en    = state == ACCESS;
  assign bus.mem_we    = (state == ACCESS) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ready   = (state == RESP) & ~grant;
  assign bus.d_ready   = (state == RESP) & grant;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_f   = bus.i_req & ~bus.i_ready;
  assign bus.stall_m   = bus.d_req & ~bus.d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, stores, reset and LATENCY=1
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int chk = 0;
  int err = 0;
  logic [31:0] mem [256];
  bit loaded;
  int acc = 0;
  mem_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus1 ();
  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .LATENCY(2)) u0 (.clk(clk), .reset(reset), .bus(bus));
  mem_arbiter #(.ADDR_W(30), .DATA_W(32), .LATENCY(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  assign bus.mem_rdata  = mem[bus.mem_addr[7:0]];
  assign bus1.mem_rdata = 32'hA5A5_0001;
  // memory model for the LATENCY=2 instance: a store lands only on the last of two access edges
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[8'h10] <= 32'h8C01_0004;
      mem[8'h40] <= 32'h1111_1111;
      loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we && acc == 1) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      acc <= acc + 1;
    end else acc <= 0;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc();
    cyc();
    #4;
    chk++; if (bus.mem_en !== 1'b0) begin err++; $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); end
    chk++; if (bus.mem_we !== 1'b0) begin err++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
    chk++; if (bus.mem_addr !== 30'h0) begin err++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
    chk++; if (bus.mem_wdata !== 32'h0) begin err++; $display("FAIL rst_mem_wdata got %h exp 0", bus.mem_wdata); end
    chk++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin err++; $display("FAIL rst_ready got %b exp 00", {bus.i_ready, bus.d_ready}); end
    chk++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin err++; $display("FAIL rst_rdata got %h/%h exp 0/0", bus.i_rdata, bus.d_rdata); end
    chk++; if ({bus.stall_f, bus.stall_m} !== 2'b00) begin err++; $display("FAIL rst_stall got %b exp 00", {bus.stall_f, bus.stall_m}); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_fetch;
    cyc();
    bus.i_req = 1'b1;
    bus.i_addr = 30'h10;
    #4;
    chk++; if (bus.stall_f !== 1'b1) begin err++; $display("FAIL f_stall_c0 got %b exp 1", bus.stall_f); end
    chk++; if (bus.mem_en !== 1'b0) begin err++; $display("FAIL f_en_c0 got %b exp 0", bus.mem_en); end
    for (int c = 1; c <= 2; c++) begin
      cyc();
      if (c == 1) bus.i_addr = 30'h20;
      #4;
      chk++; if (bus.mem_en !== 1'b1) begin err++; $display("FAIL f_en_c%0d got %b exp 1", c, bus.mem_en); end
      chk++; if (bus.mem_addr !== 30'h10) begin err++; $display("FAIL f_addr_c%0d got %h exp 10", c, bus.mem_addr); end
      chk++; if (bus.mem_we !== 1'b0) begin err++; $display("FAIL f_we_c%0d got %b exp 0", c, bus.mem_we); end
      chk++; if (bus.stall_f !== 1'b1 || bus.i_ready !== 1'b0) begin err++; $display("FAIL f_stall_c%0d got %b/%b exp 1/0", c, bus.stall_f, bus.i_ready); end
    end
    cyc();
    #4;
    chk++; if (bus.i_ready !== 1'b1) begin err++; $display("FAIL f_ready got %b exp 1", bus.i_ready); end
    chk++; if (bus.i_rdata !== 32'h8C01_0004) begin err++; $display("FAIL f_rdata got %h exp 8c010004", bus.i_rdata); end
    chk++; if (bus.stall_f !== 1'b0 || bus.mem_en !== 1'b0) begin err++; $display("FAIL f_c3 stall/en got %b/%b exp 0/0", bus.stall_f, bus.mem_en); end
    cyc();
    bus.i_req = 1'b0;
    #4;
    chk++; if (bus.i_ready !== 1'b0) begin err++; $display("FAIL f_ready_once got %b exp 0", bus.i_ready); end
    chk++; if (bus.i_rdata !== 32'h8C01_0004) begin err++; $display("FAIL f_rdata_hold got %h exp 8c010004", bus.i_rdata); end
  endtask

  task automatic test_store_load;
    cyc();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 30'h40;
    bus.d_wdata = 32'hDEAD_BEEF;
    #4;
    chk++; if (bus.stall_m !== 1'b1) begin err++; $display("FAIL s_stall got %b exp 1", bus.stall_m); end
    for (int c = 1; c <= 2; c++) begin
      cyc();
      #4;
      chk++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin err++; $display("FAIL s_en_we_c%0d got %b%b exp 11", c, bus.mem_en, bus.mem_we); end
      chk++; if (bus.mem_addr !== 30'h40 || bus.mem_wdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL s_bus_c%0d got %h/%h exp 40/deadbeef", c, bus.mem_addr, bus.mem_wdata); end
    end
    cyc();
    #4;
    chk++; if (bus.d_ready !== 1'b1 || bus.stall_m !== 1'b0) begin err++; $display("FAIL s_ready got %b/%b exp 1/0", bus.d_ready, bus.stall_m); end
    chk++; if (bus.d_rdata !== 32'h0) begin err++; $display("FAIL s_rdata_kept got %h exp 0", bus.d_rdata); end
    chk++; if (bus.mem_we !== 1'b0) begin err++; $display("FAIL s_we_resp got %b exp 0", bus.mem_we); end
    cyc();
    bus.d_we = 1'b0;
    #4;
    chk++; if (bus.mem_en !== 1'b0 || bus.d_ready !== 1'b0) begin err++; $display("FAIL l_idle got %b/%b exp 0/0", bus.mem_en, bus.d_ready); end
    cyc();
    #4;
    chk++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin err++; $display("FAIL l_access got %b%b exp 10", bus.mem_en, bus.mem_we); end
    cyc();
    cyc();
    #4;
    chk++; if (bus.d_ready !== 1'b1) begin err++; $display("FAIL l_ready got %b exp 1", bus.d_ready); end
    chk++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL l_rdata got %h exp deadbeef", bus.d_rdata); end
    cyc();
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    cyc();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 30'h40;
    bus.d_wdata = 32'hCAFE_F00D;
    cyc();
    reset = 1'b1;
    bus.d_req = 1'b0;
    #4;
    chk++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin err++; $display("FAIL rm_c1 got %b%b exp 11", bus.mem_en, bus.mem_we); end
    cyc();
    reset = 1'b0;
    #4;
    chk++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin err++; $display("FAIL rm_c2 en/we got %b%b exp 00", bus.mem_en, bus.mem_we); end
    chk++; if (bus.d_ready !== 1'b0) begin err++; $display("FAIL rm_c2 ready got %b exp 0", bus.d_ready); end
    cyc();
    #4;
    chk++; if (bus.d_ready !== 1'b0) begin err++; $display("FAIL rm_c3 ready got %b exp 0", bus.d_ready); end
    cyc();
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    cyc();
    cyc();
    cyc();
    #4;
    chk++; if (bus.d_ready !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL rm_load got %b/%h exp 1/deadbeef", bus.d_ready, bus.d_rdata); end
    cyc();
    bus.d_req = 1'b0;
  endtask

  task automatic test_contention;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    bus.i_req = 1'b1;
    bus.i_addr = 30'h10;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 30'h40;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) cyc();
      #4;
      chk++; if (bus.d_ready !== (c == 3 || c == 11)) begin err++; $display("FAIL ct_d_ready_c%0d got %b exp %b", c, bus.d_ready, c == 3 || c == 11); end
      chk++; if (bus.i_ready !== (c == 7)) begin err++; $display("FAIL ct_i_ready_c%0d got %b exp %b", c, bus.i_ready, c == 7); end
      if (c == 1 || c == 9) begin
        chk++; if (bus.mem_addr !== 30'h40) begin err++; $display("FAIL ct_addr_c%0d got %h exp 40", c, bus.mem_addr); end
      end
      if (c == 5) begin
        chk++; if (bus.mem_addr !== 30'h10) begin err++; $display("FAIL ct_addr_c5 got %h exp 10", bus.mem_addr); end
      end
      if (c == 7) begin
        chk++; if (bus.i_rdata !== 32'h8C01_0004) begin err++; $display("FAIL ct_i_rdata got %h exp 8c010004", bus.i_rdata); end
      end
      if (c == 3) begin
        chk++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL ct_d_rdata got %h exp deadbeef", bus.d_rdata); end
      end
    end
    cyc();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic test_lat1;
    cyc();
    bus1.i_req = 1'b1;
    bus1.i_addr = 30'h8;
    #4;
    chk++; if (bus1.mem_en !== 1'b0 || bus1.stall_f !== 1'b1) begin err++; $display("FAIL l1_c0 en/stall got %b/%b exp 0/1", bus1.mem_en, bus1.stall_f); end
    cyc();
    #4;
    chk++; if (bus1.mem_en !== 1'b1 || bus1.mem_addr !== 30'h8) begin err++; $display("FAIL l1_c1 en/addr got %b/%h exp 1/8", bus1.mem_en, bus1.mem_addr); end
    chk++; if (bus1.i_ready !== 1'b0) begin err++; $display("FAIL l1_c1 ready got %b exp 0", bus1.i_ready); end
    cyc();
    #4;
    chk++; if (bus1.mem_en !== 1'b0 || bus1.i_ready !== 1'b1) begin err++; $display("FAIL l1_c2 en/ready got %b/%b exp 0/1", bus1.mem_en, bus1.i_ready); end
    chk++; if (bus1.i_rdata !== 32'hA5A5_0001 || bus1.stall_f !== 1'b0) begin err++; $display("FAIL l1_c2 rdata/stall got %h/%b exp a5a50001/0", bus1.i_rdata, bus1.stall_f); end
    cyc();
    bus1.i_req = 1'b0;
    #4;
    chk++; if (bus1.i_ready !== 1'b0) begin err++; $display("FAIL l1_c3 ready got %b exp 0", bus1.i_ready); end
  endtask

  initial begin
    {bus.i_req, bus.d_req, bus.d_we} = '0;
    bus.i_addr = '0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    {bus1.i_req, bus1.d_req, bus1.d_we} = '0;
    bus1.i_addr = '0;
    bus1.d_addr = '0;
    bus1.d_wdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_reset_mid();
    test_contention();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the pipeline's instruction-fetch port and MEM-stage load/store port onto one shared single-port, fixed-latency word memory. Sits between the fetch/memory stages of the 5-stage core and the unified memory. Serialises accesses and drives the per-port stall signals that freeze the pipeline until each access completes.

## Interface
- ADDR_W, 30, word-address width (byte address bits [31:2])
- DATA_W, 32, data width
- LATENCY, 2, memory access cycles, must be ≥1
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on clk rising edge
- i_req  in  1  fetch requests a read
- i_addr  in  ADDR_W  fetch word address
- i_rdata  out  DATA_W  fetched word, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  MEM stage requests access
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data port
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last access cycle
- stall_f  out  1  freeze fetch/decode: i_req & ~i_ready (combinational)
- stall_m  out  1  freeze whole pipeline: d_req & ~d_ready (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: grant (I/D), last_grant, cnt (0..LATENCY-1), latched addr/we/wdata.
- IDLE: both req → grant port not equal to last_grant; only one req → grant it; none → stay. On grant: latch that port's addr, we (fetch forces we=0), wdata; last_grant←grant; cnt←LATENCY-1; go ACCESS.
- ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata driven from latched values, stable for all LATENCY cycles. cnt decrements each cycle; at cnt==0 capture mem_rdata into the granted port's rdata register (loads/fetches only; stores leave d_rdata unchanged); go RESP.
- RESP: granted port's ready=1 for exactly one cycle; mem_en=0; go IDLE. No arbitration in RESP, so a requester advancing on ready presents its next request in IDLE.
- Port inputs are ignored outside the IDLE grant cycle; changing addr/data or dropping req mid-access does not abort; access completes and ready still pulses.
- i_rdata/d_rdata hold last captured value between accesses.
- Store commits on the final ACCESS edge; mem_we=0 in IDLE/RESP.

## Timing
- Reset values: state IDLE, last_grant=I (so D wins first contention), cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0.
- Reset mid-ACCESS: next cycle IDLE, mem_en=mem_we=0, no ready pulse; in-flight store treated as not performed.
- req sampled in IDLE at cycle 0 → ACCESS cycles 1..LATENCY → ready in cycle LATENCY+1. Request-to-ready latency LATENCY+1; back-to-back throughput one access per LATENCY+2 cycles.
- Contention with both reqs held: grants alternate D, I, D, I…; neither port starves.
- Every LATENCY value ≥1 works; LATENCY=1 gives a single ACCESS cycle.
- stall_f/stall_m are combinational from req and registered ready; stall deasserts in the ready cycle.

## Test plan
- Fetch only, LATENCY=2: i_req=1, i_addr=0x10 at cycle 0, mem returns 0x8C010004 → mem_en cycles 1–2 with mem_addr=0x10, i_ready=1 and i_rdata=0x8C010004 in cycle 3, stall_f=1 cycles 0–2.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_we=1 cycles 1–2, d_ready cycle 3, d_rdata unchanged; then load 0x40 → d_rdata=0xDEADBEEF at its ready.
- Simultaneous i_req and d_req after reset, held → D granted first, I next, then D; ready pulses in cycles 3, 7, 11.
- Address change mid-access: i_addr switches 0x10→0x20 in cycle 1 → mem_addr stays 0x10 for cycles 1–2.
- Reset asserted in cycle 1 of a store to 0x40 → cycle 2 mem_en=0, mem_we=0, no d_ready; subsequent load of 0x40 returns prior memory contents.
- LATENCY=1 fetch → mem_en only in cycle 1, i_ready in cycle 2.
